// File: rtl/rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit.
// Each bit is sampled mid-bit, timed from the synchronized start edge.
module rx #(
    parameter int CLK_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_rx_active
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START_BIT = 3'd1;
    localparam logic [2:0] PACKET    = 3'd2;
    localparam logic [2:0] PARITY    = 3'd3;
    localparam logic [2:0] STOP_BIT  = 3'd4;

    localparam logic [7:0] HALF_CNT = 8'((CLK_PER_BIT - 1) / 2);
    localparam logic [7:0] LAST_CNT = 8'(CLK_PER_BIT - 1);

    logic       s1_q, s2_q, s2_prev_q;
    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       active_q, active_d;
    logic       start_edge;

    // Idle-high reset values keep a high line from looking like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            s2_prev_q <= 1'b1;
        end else begin
            s1_q      <= serial_in;
            s2_q      <= s1_q;
            s2_prev_q <= s2_q;
        end
    end

    assign start_edge = s2_prev_q & ~s2_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        active_d = active_q;
        case (state_q)
            IDLE: begin
                cnt_d    = 8'd0;
                idx_d    = 3'd0;
                active_d = 1'b0;
                if (start_edge) begin
                    state_d  = START_BIT;
                    active_d = 1'b1;
                end
            end
            START_BIT: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = 8'd0;
                    if (!s2_q) begin
                        state_d = PACKET;
                    end else begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PACKET: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d          = 8'd0;
                    shift_d[idx_q] = s2_q;
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PARITY: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 8'd0;
                    par_d   = s2_q;
                    state_d = STOP_BIT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STOP_BIT: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = 8'd0;
                    data_d   = shift_q;
                    perr_d   = par_q ^ (^shift_q);
                    ferr_d   = ~s2_q;
                    valid_d  = 1'b1;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = 8'd0;
                idx_d    = 3'd0;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            par_q    <= 1'b0;
            data_q   <= 8'd0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            active_q <= active_d;
        end
    end

    assign o_rx_data    = data_q;
    assign o_rx_valid   = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_rx_active  = active_q;
endmodule

// File: doc/rx.md
RX -- requirements
Module: rx

Parameters
REQ-001 SHALL provide CLK_PER_BIT, default 87, meaning clocks per serial bit; legal range 4..255.

Interface
REQ-002 SHALL have clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have serial_in  input  1  UART line from transmitter; idle high.
REQ-005 SHALL have o_rx_data  output  8  last received data byte, LSB first on the line.
REQ-006 SHALL have o_rx_valid  output  1  one-cycle pulse marking frame completion.
REQ-007 SHALL have o_parity_err  output  1  received parity bit differs from even parity of o_rx_data.
REQ-008 SHALL have o_frame_err  output  1  stop bit sampled low.
REQ-009 SHALL have o_rx_active  output  1  frame reception in progress.

Function
REQ-010 SHALL use frame format: start(0), 8 data bits LSB first, even parity bit (XOR of 8 data bits), stop(1).
REQ-011 SHALL pass serial_in through a 2-flop synchronizer; all decisions use the synchronized value (s2).
REQ-012 SHALL detect start as a falling edge of s2 (registered previous s2 = 1, s2 = 0) while in IDLE.
REQ-013 SHALL implement states IDLE, START_BIT, PACKET, PARITY, STOP_BIT; unused encodings go to IDLE.
REQ-014 IDLE: clock counter = 0, bit index = 0, o_rx_active = 0; start detect -> START_BIT, o_rx_active = 1.
REQ-015 START_BIT: count to (CLK_PER_BIT-1)/2 (43 at default); at that count, s2 = 0 -> PACKET with counter cleared; s2 = 1 -> IDLE (glitch rejected, no o_rx_valid).
REQ-016 PACKET: count to CLK_PER_BIT-1, then sample s2 into shift register bit [bit index], clear counter; after bit index 7 -> PARITY, bit index cleared.
REQ-017 PARITY: count to CLK_PER_BIT-1, then sample s2 as received parity -> STOP_BIT.
REQ-018 STOP_BIT: count to CLK_PER_BIT-1, then sample s2 and in that same cycle load o_rx_data, o_parity_err, o_frame_err, pulse o_rx_valid, go IDLE, drop o_rx_active.
REQ-019 SHALL assert o_rx_valid for every completed frame, including frames with parity or framing errors.
REQ-020 o_rx_data, o_parity_err, o_frame_err SHALL hold their values until the next o_rx_valid.
REQ-021 o_rx_valid SHALL be high exactly one clock per completed frame.
REQ-022 After a frame error (line still low), IDLE SHALL not start a new frame until s2 has returned high and fallen again.
REQ-023 Back-to-back frames: a start edge arriving on the cycle after o_rx_valid SHALL be accepted.
REQ-024 Latency: o_rx_valid SHALL assert 3 + (CLK_PER_BIT-1)/2 + 10*CLK_PER_BIT clocks (+/-2) after serial_in falls.
REQ-025 Clock counter SHALL be 8 bits; it never exceeds CLK_PER_BIT-1.
REQ-026 serial_in changes during the mid-bit sample window SHALL have no effect beyond the sampled value.

Reset
REQ-027 reset = 0 SHALL asynchronously force: state IDLE, counter 0, bit index 0, shift register 0, o_rx_data 0x00, o_rx_valid 0, o_parity_err 0, o_frame_err 0, o_rx_active 0.
REQ-028 Synchronizer and edge-detect flops SHALL reset to 1 so release of reset with line high produces no false start.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no o_rx_valid; reception resumes on the next falling edge after release.

Verification
REQ-030 Frame 0xA5, parity 0, stop 1 at CLK_PER_BIT=87 -> one o_rx_valid pulse, o_rx_data=0xA5, both error flags 0.
REQ-031 Frame 0x07 with parity bit 0 (correct is 1) -> o_rx_valid, o_rx_data=0x07, o_parity_err=1, o_frame_err=0.
REQ-032 Frame 0x3C, parity 0, stop bit driven 0 -> o_rx_valid, o_rx_data=0x3C, o_frame_err=1; no new frame until line high then low.
REQ-033 20-clock low glitch on idle line -> no o_rx_valid, o_rx_active returns 0 within 50 clocks.
REQ-034 Reset pulled low during bit 4 of 0xFF, released, then frame 0x81 parity 0 -> single o_rx_valid with 0x81, no errors.
REQ-035 Two frames 0x55 then 0xAA with zero idle gap -> two o_rx_valid pulses, data 0x55 then 0xAA, no errors.
